// File: rtl/servo_slew_limiter.sv
// ---------------------------------------------------------------------------
// servo_slew_limiter
//
// Purpose:
//   Rate-limits the X/Y/Z servo set-points coming out of the memory /
//   accelerometer source mux before they reach pwm_servos. Each axis output
//   walks toward its registered target by at most MAX_STEP counts per step
//   tick, so a playback jump or a noisy accelerometer sample cannot snap a
//   servo across its range in one PWM period. A small FSM reports motion
//   and completion to the LEDs and the playback sequencer.
//
// Ports:
//   clk            in   system clock (MAX10_CLK1_50)
//   rst            in   asynchronous, active-high reset
//   enable         in   0 freezes motion and parks the FSM in PAUSED
//   x_in/y_in/z_in in   raw targets from the source mux (BIT_SIZE, unsigned)
//   x_out/y_out/z_out
//                  out  rate-limited positions (the position registers)
//   moving         out  high while the FSM is in MOVING
//   settled_pulse  out  one-cycle pulse on the MOVING -> SETTLED transition
//
// Optional feature:
//   Define SLEW_DEADBAND_EN to ignore target differences of DEADBAND counts
//   or less when deciding whether to start a ramp from SETTLED or PAUSED.
//   Once a ramp has started it always finishes on the exact target.
// ---------------------------------------------------------------------------
module servo_slew_limiter #(
   parameter int BIT_SIZE  = 10,
   parameter int CLK_FREQ  = 50_000_000,
   parameter int STEP_FREQ = 1_000,
   parameter int MAX_STEP  = 4,
   parameter int DEADBAND  = 2,
   parameter int RESET_POS = 512
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [BIT_SIZE-1:0] x_in,
   input  logic [BIT_SIZE-1:0] y_in,
   input  logic [BIT_SIZE-1:0] z_in,
   output logic [BIT_SIZE-1:0] x_out,
   output logic [BIT_SIZE-1:0] y_out,
   output logic [BIT_SIZE-1:0] z_out,
   output logic                moving,
   output logic                settled_pulse
);

   localparam int TICK_DIV = CLK_FREQ / STEP_FREQ;
   localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [BIT_SIZE-1:0] POS_RESET = BIT_SIZE'(RESET_POS);
   localparam logic [BIT_SIZE-1:0] STEP_N    = BIT_SIZE'(MAX_STEP);
   localparam logic [BIT_SIZE:0]   STEP_W    = (BIT_SIZE + 1)'(MAX_STEP);

   // Threshold a target difference must exceed before an idle or paused
   // limiter starts a ramp. With the dead band disabled it collapses to
   // zero, so any nonzero difference starts motion.
`ifdef SLEW_DEADBAND_EN
   localparam logic [BIT_SIZE:0]   START_THRESH = (BIT_SIZE + 1)'(DEADBAND);
`else
   localparam logic [BIT_SIZE:0]   START_THRESH = (BIT_SIZE + 1)'(DEADBAND * 0);
`endif

   typedef enum logic [1:0] {
      SETTLED = 2'd0,
      MOVING  = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   state_t              state_q;
   logic                moving_q;
   logic                settledPulse_q;

   logic [CNT_W-1:0]    tickCount_q;
   logic [CNT_W-1:0]    tickCount_d;
   logic                tick;

   logic [BIT_SIZE-1:0] tgtX_q;
   logic [BIT_SIZE-1:0] tgtY_q;
   logic [BIT_SIZE-1:0] tgtZ_q;

   logic [BIT_SIZE-1:0] posX_q;
   logic [BIT_SIZE-1:0] posY_q;
   logic [BIT_SIZE-1:0] posZ_q;
   logic [BIT_SIZE-1:0] posX_d;
   logic [BIT_SIZE-1:0] posY_d;
   logic [BIT_SIZE-1:0] posZ_d;

   logic                anyMismatch;
   logic                startNeeded;

   // Magnitude of (tgt - pos). The difference is formed one bit wider than
   // a coordinate so it is a proper signed value for any pair of unsigned
   // coordinates, and its magnitude always fits back in that width.
   function automatic logic [BIT_SIZE:0] absDiff(
      input logic [BIT_SIZE-1:0] tgt,
      input logic [BIT_SIZE-1:0] pos
   );
      logic [BIT_SIZE:0] diff;
      diff = {1'b0, tgt} - {1'b0, pos};
      absDiff = diff[BIT_SIZE] ? -diff : diff;
   endfunction

   // One slew step for a single axis. If the target is within MAX_STEP we
   // land on it exactly; otherwise we move a full MAX_STEP toward it. Because
   // a full step is only taken when the remaining distance is larger than
   // MAX_STEP, the result can neither overshoot the target nor wrap.
   function automatic logic [BIT_SIZE-1:0] stepToward(
      input logic [BIT_SIZE-1:0] tgt,
      input logic [BIT_SIZE-1:0] pos
   );
      logic [BIT_SIZE:0] diff;
      diff = {1'b0, tgt} - {1'b0, pos};
      if (absDiff(tgt, pos) <= STEP_W) begin
         stepToward = tgt;
      end else if (diff[BIT_SIZE]) begin
         stepToward = pos - STEP_N;
      end else begin
         stepToward = pos + STEP_N;
      end
   endfunction

   // Step tick generation. The counter free-runs while enabled regardless of
   // FSM state, so retargeting mid-ramp never restarts the tick phase. The
   // tick itself is qualified by enable so that an edge where enable drops
   // coincident with the terminal count cannot move a position.
   assign tick = enable && (tickCount_q == CNT_LAST);

   always_comb begin
      tickCount_d = tickCount_q;
      if (!enable) begin
         tickCount_d = '0;
      end else if (tickCount_q == CNT_LAST) begin
         tickCount_d = '0;
      end else begin
         tickCount_d = tickCount_q + CNT_W'(1);
      end
   end

   // Mismatch summaries feeding the FSM. anyMismatch decides when a running
   // ramp is finished (always exact), while startNeeded decides whether an
   // idle or paused limiter should begin one (dead band applied if enabled).
   assign anyMismatch = (posX_q != tgtX_q) ||
                        (posY_q != tgtY_q) ||
                        (posZ_q != tgtZ_q);

   assign startNeeded = (absDiff(tgtX_q, posX_q) > START_THRESH) ||
                        (absDiff(tgtY_q, posY_q) > START_THRESH) ||
                        (absDiff(tgtZ_q, posZ_q) > START_THRESH);

   // Next positions. Axes are stepped independently and only on a tick while
   // MOVING; an axis already on target is returned unchanged by stepToward.
   always_comb begin
      posX_d = posX_q;
      posY_d = posY_q;
      posZ_d = posZ_q;
      if (tick && (state_q == MOVING)) begin
         posX_d = stepToward(tgtX_q, posX_q);
         posY_d = stepToward(tgtY_q, posY_q);
         posZ_d = stepToward(tgtZ_q, posZ_q);
      end
   end

   // Target capture, tick counter and position registers. Targets follow the
   // raw inputs on every edge so the ramp always heads for the latest value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgtX_q      <= POS_RESET;
         tgtY_q      <= POS_RESET;
         tgtZ_q      <= POS_RESET;
         posX_q      <= POS_RESET;
         posY_q      <= POS_RESET;
         posZ_q      <= POS_RESET;
         tickCount_q <= '0;
      end else begin
         tgtX_q      <= x_in;
         tgtY_q      <= y_in;
         tgtZ_q      <= z_in;
         posX_q      <= posX_d;
         posY_q      <= posY_d;
         posZ_q      <= posZ_d;
         tickCount_q <= tickCount_d;
      end
   end

   // Motion FSM with registered status outputs. Dropping enable always wins
   // and parks the FSM in PAUSED. A ramp finishing in MOVING is the only way
   // to produce settled_pulse; leaving PAUSED straight into SETTLED is
   // silent because no ramp actually completed there. moving_q is written
   // alongside every state change so it always mirrors the MOVING state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= SETTLED;
         moving_q       <= 1'b0;
         settledPulse_q <= 1'b0;
      end else begin
         settledPulse_q <= 1'b0;
         case (state_q)
            SETTLED: begin
               if (!enable) begin
                  state_q  <= PAUSED;
                  moving_q <= 1'b0;
               end else if (startNeeded) begin
                  state_q  <= MOVING;
                  moving_q <= 1'b1;
               end
            end
            MOVING: begin
               if (!enable) begin
                  state_q  <= PAUSED;
                  moving_q <= 1'b0;
               end else if (!anyMismatch) begin
                  state_q        <= SETTLED;
                  moving_q       <= 1'b0;
                  settledPulse_q <= 1'b1;
               end
            end
            PAUSED: begin
               if (enable) begin
                  if (startNeeded) begin
                     state_q  <= MOVING;
                     moving_q <= 1'b1;
                  end else begin
                     state_q  <= SETTLED;
                     moving_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q  <= SETTLED;
               moving_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registers; no input reaches an output
   // without passing through a flop.
   assign x_out         = posX_q;
   assign y_out         = posY_q;
   assign z_out         = posZ_q;
   assign moving        = moving_q;
   assign settled_pulse = settledPulse_q;

endmodule
